// File: rtl/tcb_lib_arbiter_rr.sv
// ---------------------------------------------------------------------------
// tcb_lib_arbiter_rr
//   Round-robin arbiter that funnels N TCB manager ports onto one TCB
//   subordinate port. Once a request is stalled by the subordinate, the grant
//   is locked so that the request cannot change until it completes. Responses
//   come back DLY cycles after each transfer and are routed to the manager
//   that issued it through a {valid, index} pipeline.
//
// Parameters
//   N    number of manager ports (2..8)
//   ADR  address width
//   DAT  data width
//   DLY  subordinate response delay in cycles (0..3)
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   man_vld/wen/adr/ben/wdt      manager requests, slice i = manager i
//   man_rdy                      per-manager ready (handshake)
//   man_rsp/rdt/err              per-manager response strobe, read data, error
//   sub_vld/wen/adr/ben/wdt      request forwarded to the subordinate
//   sub_rdy                      subordinate ready
//   sub_rdt/err                  subordinate read data / error (response cycle)
// ---------------------------------------------------------------------------
module tcb_lib_arbiter_rr #(
    parameter int N   = 2,
    parameter int ADR = 32,
    parameter int DAT = 32,
    parameter int DLY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         man_vld,
    input  logic [N-1:0]         man_wen,
    input  logic [N*ADR-1:0]     man_adr,
    input  logic [N*DAT/8-1:0]   man_ben,
    input  logic [N*DAT-1:0]     man_wdt,
    output logic [N-1:0]         man_rdy,
    output logic [N-1:0]         man_rsp,
    output logic [N*DAT-1:0]     man_rdt,
    output logic [N-1:0]         man_err,
    output logic                 sub_vld,
    output logic                 sub_wen,
    output logic [ADR-1:0]       sub_adr,
    output logic [DAT/8-1:0]     sub_ben,
    output logic [DAT-1:0]       sub_wdt,
    input  logic                 sub_rdy,
    input  logic [DAT-1:0]       sub_rdt,
    input  logic                 sub_err
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = DAT / 8;

    logic [IW-1:0]  r_ptr;
    logic           r_lock;
    logic [IW-1:0]  r_idx;

    logic [2*N-1:0] w_rot;
    logic [IW-1:0]  w_off;
    logic [IW:0]    w_sum;
    logic [IW-1:0]  w_arb;
    logic [IW-1:0]  w_gnt;
    logic [IW-1:0]  w_nxt;
    logic           w_sub_vld;
    logic           w_xfer;
    logic           w_rsp_vld;
    logic [IW-1:0]  w_rsp_idx;

    // Outputs are forced low while reset is held, even with requests pending.
    assign w_sub_vld = (|man_vld) & ~rst;
    assign w_xfer    = w_sub_vld & sub_rdy;

    // Rotate the request vector so that bit 0 corresponds to manager ptr; the
    // lowest set bit is then the offset of the winner relative to ptr.
    always_comb begin
        w_rot = {man_vld, man_vld} >> r_ptr;
        w_off = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (w_rot[j]) w_off = IW'(j);
        end
        w_sum = (IW + 1)'(r_ptr) + (IW + 1)'(w_off);
        w_arb = (w_sum >= (IW + 1)'(N)) ? IW'(w_sum - (IW + 1)'(N)) : IW'(w_sum);
    end

    // The stored index is honoured only while its manager still requests; if
    // that manager withdraws, the free arbiter takes over at once so the
    // dropped request is never presented on the subordinate side.
    assign w_gnt = (r_lock && man_vld[r_idx]) ? r_idx : w_arb;
    assign w_nxt = (w_gnt == IW'(N - 1)) ? '0 : w_gnt + 1'b1;

    always_comb begin
        sub_vld = w_sub_vld;
        sub_wen = 1'b0;
        sub_adr = '0;
        sub_ben = '0;
        sub_wdt = '0;
        man_rdy = '0;
        for (int i = 0; i < N; i++) begin
            if (w_sub_vld && (w_gnt == IW'(i))) begin
                sub_wen    = man_wen[i];
                sub_adr    = man_adr[i*ADR +: ADR];
                sub_ben    = man_ben[i*BW +: BW];
                sub_wdt    = man_wdt[i*DAT +: DAT];
                man_rdy[i] = sub_rdy & man_vld[i];
            end
        end
    end

    // Pointer and lock state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr  <= '0;
            r_lock <= 1'b0;
            r_idx  <= '0;
        end else if (w_xfer) begin
            r_ptr  <= w_nxt;
            r_lock <= 1'b0;
        end else if (w_sub_vld) begin
            r_lock <= 1'b1;
            r_idx  <= w_gnt;
        end else begin
            r_lock <= 1'b0;
        end
    end

    generate
        if (DLY == 0) begin : g_rsp_comb
            assign w_rsp_vld = w_xfer;
            assign w_rsp_idx = w_gnt;
        end else begin : g_rsp_pipe
            logic [DLY-1:0] r_vld_p;
            logic [IW-1:0]  r_idx_p [DLY];

            // Response pipeline stage boundary: one {valid, index} entry per cycle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld_p <= '0;
                    for (int j = 0; j < DLY; j++) r_idx_p[j] <= '0;
                end else begin
                    r_vld_p[0] <= w_xfer;
                    r_idx_p[0] <= w_gnt;
                    for (int j = 1; j < DLY; j++) begin
                        r_vld_p[j] <= r_vld_p[j-1];
                        r_idx_p[j] <= r_idx_p[j-1];
                    end
                end
            end

            assign w_rsp_vld = r_vld_p[DLY-1];
            assign w_rsp_idx = r_idx_p[DLY-1];
        end
    endgenerate

    // Response routing: only the owning manager sees data and error.
    always_comb begin
        man_rsp = '0;
        man_rdt = '0;
        man_err = '0;
        for (int i = 0; i < N; i++) begin
            if (w_rsp_vld && !rst && (w_rsp_idx == IW'(i))) begin
                man_rsp[i]             = 1'b1;
                man_rdt[i*DAT +: DAT]  = sub_rdt;
                man_err[i]             = sub_err;
            end
        end
    end

endmodule

// File: tb/tb_tcb_lib_arbiter_rr.sv
module tb_tcb_lib_arbiter_rr;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  man_vld, man_wen, man_rdy, man_rsp, man_err;
    logic [63:0] man_adr, man_wdt, man_rdt;
    logic [7:0]  man_ben;
    logic        sub_vld, sub_wen, sub_rdy, sub_err;
    logic [31:0] sub_adr, sub_wdt, sub_rdt;
    logic [3:0]  sub_ben;

    int checks = 0;
    int errors = 0;

    tcb_lib_arbiter_rr #(.N(2), .ADR(32), .DAT(32), .DLY(1)) dut (
        .clk(clk), .rst(rst),
        .man_vld(man_vld), .man_wen(man_wen), .man_adr(man_adr), .man_ben(man_ben),
        .man_wdt(man_wdt), .man_rdy(man_rdy), .man_rsp(man_rsp), .man_rdt(man_rdt),
        .man_err(man_err),
        .sub_vld(sub_vld), .sub_wen(sub_wen), .sub_adr(sub_adr), .sub_ben(sub_ben),
        .sub_wdt(sub_wdt), .sub_rdy(sub_rdy), .sub_rdt(sub_rdt), .sub_err(sub_err)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_man(input int i, input logic v, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
        man_vld[i]          = v;
        man_wen[i]          = w;
        man_adr[i*32 +: 32] = a;
        man_wdt[i*32 +: 32] = d;
        man_ben[i*4 +: 4]   = w ? 4'hf : 4'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1; sub_rdy = 1'b1; sub_rdt = 32'hdeadbeef; sub_err = 1'b1;
        set_man(0, 1'b1, 1'b1, 32'h40, 32'h11); set_man(1, 1'b1, 1'b0, 32'h44, 32'h22);
        #1;
        checks++; if (sub_vld !== 1'b0) begin errors++; $display("FAIL reset_sub_vld got=%b exp=0", sub_vld); end
        checks++; if (sub_adr !== 32'h0) begin errors++; $display("FAIL reset_sub_adr got=%h exp=0", sub_adr); end
        checks++; if (sub_wdt !== 32'h0 || sub_wen !== 1'b0 || sub_ben !== 4'h0) begin errors++; $display("FAIL reset_sub_fields wdt=%h wen=%b ben=%h exp=0", sub_wdt, sub_wen, sub_ben); end
        checks++; if (man_rdy !== 2'b00) begin errors++; $display("FAIL reset_man_rdy got=%b exp=00", man_rdy); end
        checks++; if (man_rsp !== 2'b00 || man_rdt !== 64'h0 || man_err !== 2'b00) begin errors++; $display("FAIL reset_man_rsp rsp=%b rdt=%h err=%b exp=0", man_rsp, man_rdt, man_err); end
        tick(); tick();
        checks++; if (dut.r_ptr !== 1'b0) begin errors++; $display("FAIL reset_ptr got=%0d exp=0", dut.r_ptr); end
        set_man(0, 1'b0, 1'b0, 32'h0, 32'h0); set_man(1, 1'b0, 1'b0, 32'h0, 32'h0);
        sub_err = 1'b0; sub_rdt = 32'h0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_simul_write();
        set_man(0, 1'b1, 1'b1, 32'h00, 32'h01234567);
        set_man(1, 1'b1, 1'b1, 32'h04, 32'h76543210);
        #1;
        checks++; if (sub_adr !== 32'h00 || sub_wdt !== 32'h01234567) begin errors++; $display("FAIL wr_c0_sub got adr=%h wdt=%h exp adr=00 wdt=01234567", sub_adr, sub_wdt); end
        checks++; if (sub_wen !== 1'b1 || sub_ben !== 4'hf || man_rdy !== 2'b01) begin errors++; $display("FAIL wr_c0_ctrl wen=%b ben=%h rdy=%b exp 1 f 01", sub_wen, sub_ben, man_rdy); end
        checks++; if (dut.r_ptr !== 1'b0) begin errors++; $display("FAIL wr_c0_ptr got=%0d exp=0", dut.r_ptr); end
        tick();
        set_man(0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checks++; if (sub_adr !== 32'h04 || sub_wdt !== 32'h76543210) begin errors++; $display("FAIL wr_c1_sub got adr=%h wdt=%h exp adr=04 wdt=76543210", sub_adr, sub_wdt); end
        checks++; if (man_rdy !== 2'b10 || dut.r_ptr !== 1'b1) begin errors++; $display("FAIL wr_c1_rdy_ptr rdy=%b ptr=%0d exp 10 1", man_rdy, dut.r_ptr); end
        checks++; if (man_rsp !== 2'b01) begin errors++; $display("FAIL wr_c1_rsp got=%b exp=01", man_rsp); end
        tick();
        set_man(1, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checks++; if (man_rsp !== 2'b10 || sub_vld !== 1'b0) begin errors++; $display("FAIL wr_c2_rsp rsp=%b vld=%b exp 10 0", man_rsp, sub_vld); end
        checks++; if (dut.r_ptr !== 1'b0) begin errors++; $display("FAIL wr_c2_ptr got=%0d exp=0", dut.r_ptr); end
    endtask

    task automatic test_alternate_reads();
        logic [31:0] e0, e1;
        tick();
        set_man(0, 1'b1, 1'b0, 32'h10, 32'h0);
        set_man(1, 1'b1, 1'b0, 32'h14, 32'h0);
        for (int c = 0; c <= 6; c++) begin
            if (c == 6) begin
                set_man(0, 1'b0, 1'b0, 32'h0, 32'h0);
                set_man(1, 1'b0, 1'b0, 32'h0, 32'h0);
            end
            sub_rdt = 32'h1000 + c;
            #1;
            if (c < 6) begin
                checks++; if (man_rdy !== (2'b01 << (c % 2))) begin errors++; $display("FAIL alt_gnt c=%0d rdy=%b exp=%b", c, man_rdy, 2'b01 << (c % 2)); end
                checks++; if (sub_adr !== ((c % 2 == 0) ? 32'h10 : 32'h14)) begin errors++; $display("FAIL alt_adr c=%0d got=%h", c, sub_adr); end
            end
            if (c > 0) begin
                e0 = ((c - 1) % 2 == 0) ? sub_rdt : 32'h0;
                e1 = ((c - 1) % 2 == 1) ? sub_rdt : 32'h0;
                checks++; if (man_rsp !== (2'b01 << ((c - 1) % 2))) begin errors++; $display("FAIL alt_rsp c=%0d got=%b exp=%b", c, man_rsp, 2'b01 << ((c - 1) % 2)); end
                checks++; if (man_rdt[31:0] !== e0 || man_rdt[63:32] !== e1) begin errors++; $display("FAIL alt_rdt c=%0d got=%h exp=%h%h", c, man_rdt, e1, e0); end
            end
            tick();
        end
        sub_rdt = 32'h0;
    endtask

    task automatic test_stall();
        set_man(1, 1'b1, 1'b0, 32'h08, 32'h0);
        sub_rdy = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (s == 1) set_man(0, 1'b1, 1'b0, 32'h0c, 32'h0);
            #1;
            checks++; if (sub_adr !== 32'h08 || man_rdy !== 2'b00) begin errors++; $display("FAIL stall_hold s=%0d adr=%h rdy=%b exp 08 00", s, sub_adr, man_rdy); end
            tick();
        end
        sub_rdy = 1'b1;
        #1;
        checks++; if (sub_adr !== 32'h08 || man_rdy !== 2'b10) begin errors++; $display("FAIL stall_release adr=%h rdy=%b exp 08 10", sub_adr, man_rdy); end
        tick();
        set_man(1, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checks++; if (sub_adr !== 32'h0c || man_rdy !== 2'b01 || man_rsp !== 2'b10) begin errors++; $display("FAIL stall_next adr=%h rdy=%b rsp=%b exp 0c 01 10", sub_adr, man_rdy, man_rsp); end
        tick();
        set_man(0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checks++; if (man_rsp !== 2'b01 || dut.r_ptr !== 1'b1) begin errors++; $display("FAIL stall_done rsp=%b ptr=%0d exp 01 1", man_rsp, dut.r_ptr); end
        tick();
    endtask

    task automatic test_error_routing();
        set_man(0, 1'b1, 1'b0, 32'h20, 32'h0);
        #1;
        checks++; if (man_rdy !== 2'b01) begin errors++; $display("FAIL err_gnt got=%b exp=01", man_rdy); end
        tick();
        set_man(0, 1'b0, 1'b0, 32'h0, 32'h0);
        sub_rdt = 32'h89abcdef; sub_err = 1'b1;
        #1;
        checks++; if (man_rdt[31:0] !== 32'h89abcdef || man_err[0] !== 1'b1) begin errors++; $display("FAIL err_owner rdt=%h err=%b exp 89abcdef 1", man_rdt[31:0], man_err[0]); end
        checks++; if (man_rsp !== 2'b01 || man_rdt[63:32] !== 32'h0 || man_err[1] !== 1'b0) begin errors++; $display("FAIL err_other rsp=%b rdt1=%h err1=%b exp 01 0 0", man_rsp, man_rdt[63:32], man_err[1]); end
        tick();
        sub_rdt = 32'h0; sub_err = 1'b0;
    endtask

    task automatic test_reset_inflight();
        set_man(0, 1'b1, 1'b1, 32'h30, 32'h5a5a5a5a);
        #1;
        checks++; if (man_rdy !== 2'b01) begin errors++; $display("FAIL rst_if_gnt got=%b exp=01", man_rdy); end
        tick();
        set_man(0, 1'b0, 1'b0, 32'h0, 32'h0);
        sub_rdt = 32'hcafef00d;
        rst = 1'b1;
        #1;
        checks++; if (man_rsp !== 2'b00 || man_rdt !== 64'h0 || sub_vld !== 1'b0) begin errors++; $display("FAIL rst_if_outputs rsp=%b rdt=%h vld=%b exp 0", man_rsp, man_rdt, sub_vld); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (man_rsp !== 2'b00) begin errors++; $display("FAIL rst_if_rsp_rel got=%b exp=00", man_rsp); end
        tick();
        checks++; if (man_rsp !== 2'b00) begin errors++; $display("FAIL rst_if_rsp_late got=%b exp=00", man_rsp); end
        set_man(0, 1'b1, 1'b0, 32'h50, 32'h0);
        set_man(1, 1'b1, 1'b0, 32'h54, 32'h0);
        #1;
        checks++; if (man_rdy !== 2'b01 || sub_adr !== 32'h50) begin errors++; $display("FAIL rst_if_first_gnt rdy=%b adr=%h exp 01 50", man_rdy, sub_adr); end
        tick();
        set_man(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_man(1, 1'b0, 1'b0, 32'h0, 32'h0);
        sub_rdt = 32'h0;
        tick(); tick();
    endtask

    task automatic test_drop_lock();
        sub_rdy = 1'b0;
        set_man(0, 1'b1, 1'b0, 32'h60, 32'h0);
        tick();
        set_man(0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checks++; if (sub_vld !== 1'b0 || sub_adr !== 32'h0) begin errors++; $display("FAIL drop_spurious vld=%b adr=%h exp 0 0", sub_vld, sub_adr); end
        tick();
        sub_rdy = 1'b1;
        set_man(1, 1'b1, 1'b0, 32'h64, 32'h0);
        #1;
        checks++; if (man_rdy !== 2'b10 || sub_adr !== 32'h64) begin errors++; $display("FAIL drop_resume rdy=%b adr=%h exp 10 64", man_rdy, sub_adr); end
        tick();
        set_man(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_back_to_back();
        set_man(1, 1'b1, 1'b0, 32'h70, 32'h0);
        for (int c = 0; c <= 4; c++) begin
            if (c == 4) set_man(1, 1'b0, 1'b0, 32'h0, 32'h0);
            sub_rdt = 32'hb000 + c;
            #1;
            if (c < 4) begin
                checks++; if (man_rdy !== 2'b10) begin errors++; $display("FAIL b2b_rdy c=%0d got=%b exp=10", c, man_rdy); end
            end
            if (c > 0) begin
                checks++; if (man_rsp !== 2'b10 || man_rdt[63:32] !== (32'hb000 + c) || man_rdt[31:0] !== 32'h0) begin errors++; $display("FAIL b2b_rsp c=%0d rsp=%b rdt=%h", c, man_rsp, man_rdt); end
                checks++; if (dut.r_ptr !== 1'b0) begin errors++; $display("FAIL b2b_ptr c=%0d got=%0d exp=0", c, dut.r_ptr); end
            end
            tick();
        end
        #1;
        checks++; if (man_rsp !== 2'b00) begin errors++; $display("FAIL b2b_tail got=%b exp=00", man_rsp); end
    endtask

    initial begin
        man_vld = '0; man_wen = '0; man_adr = '0; man_ben = '0; man_wdt = '0;
        sub_rdy = 1'b1; sub_rdt = '0; sub_err = 1'b0; rst = 1'b0;
        #1;
        test_reset();
        test_simul_write();
        test_alternate_reads();
        test_stall();
        test_error_routing();
        test_reset_inflight();
        test_drop_lock();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tcb_lib_arbiter_rr.md
TCB_LIB_ARBITER_RR -- requirements
Module: tcb_lib_arbiter_rr

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- N, 2, number of manager ports, legal 2..8
- ADR, 32, address width
- DAT, 32, data width
- DLY, 1, subordinate response delay in cycles, legal 0..3
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, clock
- rst, in, 1, reset; one clock, asynchronous, active-high
- man_vld, in, N, manager request valid
- man_wen, in, N, manager write enable
- man_adr, in, N*ADR, manager address; slice i belongs to manager i
- man_ben, in, N*DAT/8, manager byte enables
- man_wdt, in, N*DAT, manager write data
- man_rdy, out, N, manager ready
- man_rsp, out, N, manager response strobe
- man_rdt, out, N*DAT, manager read data
- man_err, out, N, manager error
- sub_vld, out, 1, subordinate request valid
- sub_wen, out, 1, subordinate write enable
- sub_adr, out, ADR, subordinate address
- sub_ben, out, DAT/8, subordinate byte enables
- sub_wdt, out, DAT, subordinate write data
- sub_rdy, in, 1, subordinate ready
- sub_rdt, in, DAT, subordinate read data
- sub_err, in, 1, subordinate error

Function
REQ-003 A transfer on any port SHALL occur in a cycle where vld and rdy are both high.
REQ-004 Arbitration SHALL be round-robin with a registered pointer ptr of width clog2(N).
REQ-005 When unlocked, the granted index gnt SHALL be the first i with man_vld[i]=1, searching from ptr upward modulo N.
REQ-006 sub_vld SHALL equal the OR of all man_vld bits.
REQ-007 sub_wen, sub_adr, sub_ben and sub_wdt SHALL be the fields of manager gnt, and SHALL be 0 when sub_vld=0.
REQ-008 man_rdy[i] SHALL equal sub_rdy AND man_vld[i] AND (gnt==i); all other man_rdy bits SHALL be 0.
REQ-009 When sub_vld=1 and sub_rdy=0, lock SHALL be set and the gnt index stored. While lock=1, gnt SHALL be the stored index, so no regrant can happen during a stall.
REQ-010 lock SHALL clear in the cycle of the subordinate transfer.
REQ-011 On each subordinate transfer, ptr SHALL be set to (gnt+1) mod N.
REQ-012 With no transfer, ptr SHALL hold its value.
REQ-013 A DLY-deep response pipeline SHALL carry {valid, gnt} per transfer, one entry per cycle, which allows back-to-back transfers.
REQ-014 man_rsp[k] SHALL pulse exactly DLY cycles after the transfer, where k is that transfer's index.
REQ-015 In the man_rsp cycle, man_rdt[k] SHALL equal sub_rdt and man_err[k] SHALL equal sub_err.
REQ-016 Non-owner man_rdt and man_err slices SHALL be 0.
REQ-017 For DLY=0, the response SHALL be combinational in the transfer cycle itself.
REQ-018 If man_vld[i] drops while locked on i, lock SHALL clear in the next cycle and arbitration SHALL resume. This protocol violation SHALL NOT raise sub_vld spuriously for manager i.
REQ-019 A single requester SHALL receive every cycle (full throughput). ptr wrap from N-1 to 0 SHALL be seamless.

Reset
REQ-020 Asserting rst SHALL immediately clear ptr, lock, the stored index and all response pipeline entries.
REQ-021 During reset, all outputs SHALL be 0.
REQ-022 Responses in flight when reset is asserted SHALL be discarded, with no man_rsp pulse after reset release.
REQ-023 The first grant after reset SHALL search from manager 0.

Verification (N=2, DLY=1, sub_rdy=1 unless stated)
REQ-024 After reset, manager 0 write adr 0x00 wdt 0x01234567 and manager 1 write adr 0x04 wdt 0x76543210, both vld at the same time:
- cycle 0: sub_adr=0x00
- cycle 1: sub_adr=0x04
- ptr sequence: 0, 1, 0
- man_rsp[0] in cycle 1, man_rsp[1] in cycle 2
REQ-025 Both managers hold continuous reads for 6 cycles:
- grants alternate 0,1,0,1,0,1
- each man_rsp pulses 1 cycle after its transfer
- man_rdt routed only to the owner, other slice 0
REQ-026 Manager 1 reads adr 0x08 with sub_rdy=0 for 3 cycles; manager 0 raises vld in stall cycle 1:
- sub_adr stays 0x08 for all stall cycles
- manager 1 transfers first
- manager 0 is granted the next cycle
REQ-027 Subordinate returns sub_rdt=0x89abcdef with sub_err=1 for a manager 0 read:
- man_rdt[0]=0x89abcdef, man_err[0]=1
- man_rsp[1]=0, man_rdt[1]=0
REQ-028 Assert rst one cycle after a manager 0 transfer:
- all outputs 0 immediately
- no man_rsp pulse after release
- next simultaneous request grants manager 0
REQ-029 Manager 1 alone issues 4 back-to-back reads:
- man_rdy[1]=1 in every cycle
- 4 man_rsp[1] pulses, each 1 cycle delayed
- ptr stays 0 (wraps from 1 to 0 on each transfer)
